// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE single field widths, special constants,
// fflags bit positions and the divider FSM encoding.
package fpu_pkg;

    localparam int EXPW  = 8;
    localparam int FRACW = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF   = 32'h7F80_0000;

    // fflags bit positions, RISC-V order {NV,DZ,OF,UF,NX}
    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } div_state_t;

    typedef struct packed {
        logic [31:0] q;
        logic [4:0]  flags;
    } fp_res_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE single operand classifier. Denormals are treated as
// zero (any exponent of 0 reports is_zero).
module fp_classify
    import fpu_pkg::*;
(
    input  logic [31:0]     x,
    output logic            is_zero,
    output logic            is_inf,
    output logic            is_nan,
    output logic            sign,
    output logic [EXPW-1:0] exp,
    output logic [FRACW:0]  man
);

    logic [FRACW-1:0] frac;

    // Split fields and derive the operand class
    always_comb begin
        sign    = x[31];
        exp     = x[30:23];
        frac    = x[22:0];
        man     = {1'b1, frac};
        is_zero = (exp == '0);
        is_inf  = (exp == '1) && (frac == '0);
        is_nan  = (exp == '1) && (frac != '0);
    end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE single divider, restoring division one quotient bit per
// cycle. Denormals flush to zero, results truncate toward zero. One
// operation outstanding; the tag travels with the request to the response.
module fp_div_iter
    import fpu_pkg::*;
#(
    parameter int          TAGW = 8,
    parameter logic [31:0] CNAN = CANON_NAN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_q,
    output logic [TAGW-1:0] out_tag,
    output logic [4:0]      out_fflags
);

    div_state_t state, state_next;

    logic a_zero, a_inf, a_nan, a_sign;
    logic b_zero, b_inf, b_nan, b_sign;
    logic [EXPW-1:0] a_exp, b_exp;
    logic [FRACW:0]  a_man, b_man;

    logic                sign_r;
    logic signed [9:0]   e_r;
    logic [24:0]         r_r;
    logic [24:0]         q_r;
    logic [FRACW:0]      mb_r;
    logic [4:0]          cnt;
    logic [TAGW-1:0]     tag_r;

    logic                special;
    logic [31:0]         spec_q;
    logic [4:0]          spec_flags;
    logic signed [9:0]   e_calc;
    logic signed [9:0]   ea_s, eb_s;
    logic [24:0]         diff;
    logic                r_ge;
    fp_res_t             norm_res;

    fp_classify u_cls_a (
        .x       (in_a),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan),
        .sign    (a_sign),
        .exp     (a_exp),
        .man     (a_man)
    );

    fp_classify u_cls_b (
        .x       (in_b),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan),
        .sign    (b_sign),
        .exp     (b_exp),
        .man     (b_man)
    );

    // Normalise the 25-bit quotient, truncate, and saturate the exponent.
    // Overflow and underflow both imply lost information, so NX always goes
    // along with OF/UF.
    function automatic fp_res_t norm_pack(
        input logic              s,
        input logic signed [9:0] e,
        input logic [24:0]       q,
        input logic              rem_nz
    );
        fp_res_t           res;
        logic signed [9:0] exp_n;
        logic [22:0]       frac;
        logic              inexact;
        res = '0;
        if (q[24]) begin
            frac    = q[23:1];
            exp_n   = e;
            inexact = q[0] | rem_nz;
        end else begin
            frac    = q[22:0];
            exp_n   = e - 10'sd1;
            inexact = rem_nz;
        end
        if (exp_n >= 10'sd255) begin
            res.q            = {s, 8'hFF, 23'd0};
            res.flags[FF_OF] = 1'b1;
            res.flags[FF_NX] = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            res.q            = {s, 31'd0};
            res.flags[FF_UF] = 1'b1;
            res.flags[FF_NX] = 1'b1;
        end else begin
            res.q            = {s, exp_n[7:0], frac};
            res.flags[FF_NX] = inexact;
        end
        return res;
    endfunction

    // Special-operand detection with fixed priority; exponent difference is
    // kept 10-bit signed so out-of-range results never wrap
    always_comb begin
        special    = 1'b1;
        spec_q     = '0;
        spec_flags = '0;
        ea_s       = {2'b00, a_exp};
        eb_s       = {2'b00, b_exp};
        e_calc     = ea_s - eb_s + 10'sd127;
        if (a_nan || b_nan) begin
            spec_q            = CNAN;
            spec_flags[FF_NV] = 1'b1;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_q            = CNAN;
            spec_flags[FF_NV] = 1'b1;
        end else if (b_zero && !a_inf) begin
            spec_q            = {a_sign ^ b_sign, POS_INF[30:0]};
            spec_flags[FF_DZ] = 1'b1;
        end else if (a_inf) begin
            spec_q = {a_sign ^ b_sign, POS_INF[30:0]};
        end else if (a_zero || b_inf) begin
            spec_q = {a_sign ^ b_sign, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    // Restoring step: trial subtract of the divisor from the partial remainder
    always_comb begin
        diff     = r_r - {1'b0, mb_r};
        r_ge     = (r_r >= {1'b0, mb_r});
        norm_res = norm_pack(sign_r, e_r, q_r, (r_r != '0));
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = special ? DONE : DIV;
            DIV:  if (cnt == 5'd24) state_next = NORM;
            NORM: state_next = DONE;
            DONE: if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state == IDLE);
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_r     <= 1'b0;
            e_r        <= '0;
            r_r        <= '0;
            q_r        <= '0;
            mb_r       <= '0;
            cnt        <= '0;
            tag_r      <= '0;
            out_valid  <= 1'b0;
            out_q      <= '0;
            out_tag    <= '0;
            out_fflags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= a_sign ^ b_sign;
                        e_r    <= e_calc;
                        r_r    <= {1'b0, a_man};
                        mb_r   <= b_man;
                        q_r    <= '0;
                        cnt    <= '0;
                        tag_r  <= in_tag;
                        if (special) begin
                            out_q      <= spec_q;
                            out_tag    <= in_tag;
                            out_fflags <= spec_flags;
                        end
                    end
                end
                DIV: begin
                    if (r_ge) begin
                        r_r <= {diff[23:0], 1'b0};
                    end else begin
                        r_r <= {r_r[23:0], 1'b0};
                    end
                    q_r <= {q_r[23:0], r_ge};
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    out_q      <= norm_res.q;
                    out_fflags <= norm_res.flags;
                    out_tag    <= tag_r;
                    out_valid  <= 1'b1;
                end
                DONE: begin
                    // Special results arrive here with out_valid still low
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed testbench for fp_div_iter: normal quotients, special operands,
// exponent saturation, backpressure and asynchronous reset mid-operation.
module tb_fp_div_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_q;
    logic [7:0]  out_tag;
    logic [4:0]  out_fflags;

    int checks   = 0;
    int failures = 0;

    fp_div_iter #(.TAGW(8), .CNAN(32'h7FC00000)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_q      (out_q),
        .out_tag    (out_tag),
        .out_fflags (out_fflags)
    );

    always #5 clk = ~clk;

    // Drive one request and return the number of edges from acceptance
    // until out_valid is seen (capped at 100).
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] tag, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if ({out_q, out_tag, out_fflags} !== 45'd0) begin
            failures++;
            $display("FAIL reset_outputs got q=%h tag=%h fl=%h exp all zero", out_q, out_tag, out_fflags);
        end
        checks++;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_normal();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [31:0] vq [6];
        logic [4:0]  vf [6];
        int lat;
        va = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h40400000, 32'h7F000000, 32'h00800000};
        vb = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h40000000, 32'h3E800000, 32'h40000000};
        vq = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'h3FC00000, 32'h7F800000, 32'h00000000};
        vf = '{5'h00,        5'h01,        5'h00,        5'h00,        5'h05,        5'h03};
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], 8'h10 + 8'(i), lat);
            if (out_q !== vq[i]) begin failures++; $display("FAIL norm_q[%0d] got=%h exp=%h", i, out_q, vq[i]); end
            checks++;
            if (out_fflags !== vf[i]) begin failures++; $display("FAIL norm_flags[%0d] got=%h exp=%h", i, out_fflags, vf[i]); end
            checks++;
            if (out_tag !== 8'h10 + 8'(i)) begin failures++; $display("FAIL norm_tag[%0d] got=%h exp=%h", i, out_tag, 8'h10 + 8'(i)); end
            checks++;
            if (lat != 26) begin failures++; $display("FAIL norm_latency[%0d] got=%0d exp=26", i, lat); end
            checks++;
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL norm_release[%0d] got valid=%b ready=%b exp valid=0 ready=1", i, out_valid, in_ready);
            end
            checks++;
        end
    endtask

    task automatic test_special();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [31:0] vq [10];
        logic [4:0]  vf [10];
        int lat;
        va = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7FC00001, 32'hFF800000,
               32'h80000000, 32'h40000000, 32'h7F800000, 32'h00000001, 32'hBF800000};
        vb = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h3F800000, 32'h40000000,
               32'h40000000, 32'h7F800000, 32'h00000000, 32'h3F800000, 32'h00000000};
        vq = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
               32'h80000000, 32'h00000000, 32'h7F800000, 32'h00000000, 32'hFF800000};
        vf = '{5'h08, 5'h10, 5'h10, 5'h10, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h08};
        for (int i = 0; i < 10; i++) begin
            issue(va[i], vb[i], 8'hA0 + 8'(i), lat);
            if (out_q !== vq[i]) begin failures++; $display("FAIL spec_q[%0d] got=%h exp=%h", i, out_q, vq[i]); end
            checks++;
            if (out_fflags !== vf[i]) begin failures++; $display("FAIL spec_flags[%0d] got=%h exp=%h", i, out_fflags, vf[i]); end
            checks++;
            if (out_tag !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL spec_tag[%0d] got=%h exp=%h", i, out_tag, 8'hA0 + 8'(i)); end
            checks++;
            if (lat != 1) begin failures++; $display("FAIL spec_latency[%0d] got=%0d exp=1", i, lat); end
            checks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        issue(32'h40C00000, 32'h40000000, 8'h5A, lat);
        if (lat != 26) begin failures++; $display("FAIL bp_latency got=%0d exp=26", lat); end
        checks++;
        // A second request is presented and held while the result is stalled
        in_a = 32'h3F800000; in_b = 32'h40400000; in_tag = 8'h6B; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_q !== 32'h40400000 || out_tag !== 8'h5A ||
                out_fflags !== 5'h00 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%b q=%h tag=%h fl=%h rdy=%b exp v=1 q=40400000 tag=5a fl=00 rdy=0",
                         i, out_valid, out_q, out_tag, out_fflags, in_ready);
            end
            checks++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_handshake got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
        checks++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_accept got rdy=%b exp 0", in_ready); end
        checks++;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (lat != 26 || out_q !== 32'h3EAAAAAA || out_tag !== 8'h6B || out_fflags !== 5'h01) begin
            failures++;
            $display("FAIL bp_second got lat=%0d q=%h tag=%h fl=%h exp lat=26 q=3eaaaaaa tag=6b fl=01",
                     lat, out_q, out_tag, out_fflags);
        end
        checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int w;
        int stale;
        int lat;
        w = 0;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        in_a = 32'h40C00000; in_b = 32'h40000000; in_tag = 8'h33; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL arst_busy got rdy=%b exp 0", in_ready); end
        checks++;
        #1 reset = 1'b0;
        #1;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL arst_immediate got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
        checks++;
        #3 reset = 1'b1;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        if (stale != 0) begin failures++; $display("FAIL arst_stale got=%0d exp=0", stale); end
        checks++;
        issue(32'h40C00000, 32'h40000000, 8'h44, lat);
        if (lat != 26 || out_q !== 32'h40400000 || out_tag !== 8'h44 || out_fflags !== 5'h00) begin
            failures++;
            $display("FAIL arst_recover got lat=%0d q=%h tag=%h fl=%h exp lat=26 q=40400000 tag=44 fl=00",
                     lat, out_q, out_tag, out_fflags);
        end
        checks++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_backpressure();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
